if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter PC_W, default 11, program-counter width in bits (word address).
REQ-002 The block SHALL have parameter INSTR_W, default 32, instruction width in bits.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_in  input  PC_W  current PC, driven by the pc register output.
REQ-006 instr_in  input  INSTR_W  instruction-memory data for pc_in, valid in the same cycle.
REQ-007 stall  input  1  hazard unit request to hold fetch and the IF/ID register.
REQ-008 flush  input  1  taken branch/jump; squash the fetched instruction.
REQ-009 target  input  PC_W  branch/jump destination, sampled only when flush=1.
REQ-010 pc_next  output  PC_W  next PC value, fed back to the pc register input.
REQ-011 pc_out  output  PC_W  registered PC of the instruction held for decode.
REQ-012 instr_out  output  INSTR_W  registered instruction for decode.
REQ-013 valid_out  output  1  registered; 1 = instr_out is a real instruction, 0 = bubble.

Function
REQ-014 pc_next SHALL be combinational with priority: reset -> 0; flush -> target; stall -> pc_in; otherwise pc_in+1.
REQ-015 pc_in+1 SHALL be computed modulo 2^PC_W (0x7FF+1 = 0x000 for PC_W=11), with no carry out.
REQ-016 Register update priority on each rising edge SHALL be reset > flush > stall > load.
REQ-017 Load (no reset/flush/stall) SHALL capture pc_out<=pc_in, instr_out<=instr_in, valid_out<=1; latency pc_in to pc_out is one cycle.
REQ-018 Stall SHALL hold pc_out, instr_out and valid_out unchanged for every stalled cycle, any number of cycles.
REQ-019 Flush SHALL set instr_out<=0 (NOP), valid_out<=0, pc_out<=pc_in, regardless of stall.
REQ-020 State machine SHALL have states EMPTY, FULL, BUBBLE, encoded in a 2-bit register.
REQ-021 Transitions: EMPTY/BUBBLE -load-> FULL; any -flush-> BUBBLE; FULL -stall-> FULL; EMPTY -stall-> EMPTY; BUBBLE -stall-> BUBBLE.
REQ-022 valid_out SHALL equal 1 exactly when state is FULL.
REQ-023 Simultaneous flush and stall SHALL behave as flush alone, both for pc_next and for the registers.
REQ-024 Flush on consecutive cycles SHALL produce one bubble per cycle, and pc_next SHALL follow the latest target.
REQ-025 X on instr_in while stall=1 or flush=1 SHALL NOT propagate to instr_out.

Reset
REQ-026 While reset=1, on each edge: pc_out=0, instr_out=0, valid_out=0, state=EMPTY; pc_next=0 combinationally.
REQ-027 Reset asserted mid-stall or mid-flush SHALL take effect on the next edge; stall and flush SHALL be ignored while reset=1.
REQ-028 On the first edge after reset deasserts, with no stall/flush, the block SHALL load pc_in=0 and move to FULL.

Configuration
REQ-029 With macro IF_ID_STALL_CNT_EN defined, the block SHALL add output stall_cnt [15:0]: increments once per edge with stall=1, flush=0, reset=0 and state=FULL; saturates at 0xFFFF; cleared by reset.
REQ-030 Without IF_ID_STALL_CNT_EN, port stall_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset 3 cycles, then free-run with instr_in=0x20000000+pc_in -> pc_out sequence 0,1,2,...; valid_out=1 from the first edge after reset; instr_out=0x20000000+pc_out.
REQ-032 stall=1 for 4 cycles at pc_in=5 -> pc_next=5, pc_out/instr_out frozen, valid_out=1; after release pc_out=5 then 6; stall_cnt=4 if enabled.
REQ-033 flush=1 with target=0x123 at pc_in=9 -> pc_next=0x123 the same cycle; next edge valid_out=0, instr_out=0; following edge pc_out=0x123, valid_out=1.
REQ-034 flush=1 and stall=1 together, target=0x040 -> identical to REQ-033 response; stall_cnt does not increment.
REQ-035 pc_in=0x7FF, no stall/flush -> pc_next=0x000; pc_out=0x7FF then 0x000.
REQ-036 reset=1 during stall with state FULL -> next edge valid_out=0, pc_out=0, state EMPTY; stall_cnt=0.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch/decode bus of the IF/ID stage: PC, instruction, hazard controls and decode outputs.
// The stage sits on the slave modport; the fetch/hazard side drives the master modport.
interface if_id_stage_if #(
  parameter int unsigned PC_W    = 11,
  parameter int unsigned INSTR_W = 32
);
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic               valid_out;

  modport slave (
    input  pc_in, instr_in, stall, flush, target,
    output pc_next, pc_out, instr_out, valid_out
  );

  modport master (
    output pc_in, instr_in, stall, flush, target,
    input  pc_next, pc_out, instr_out, valid_out
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: next-PC select plus the IF/ID register with an EMPTY/FULL/BUBBLE FSM.
// Optional macro IF_ID_STALL_CNT_EN adds a saturating 16-bit count of stalls while FULL.
module if_id_stage #(
  parameter int unsigned PC_W    = 11,
  parameter int unsigned INSTR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
`ifdef IF_ID_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  if_id_stage_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    FULL   = 2'b01,
    BUBBLE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_inc;

  // Width of the sum matches pc_in, so the increment wraps with no carry out.
  assign pc_inc = bus.pc_in + PC_W'(1);

  always_comb begin
    bus.pc_next = pc_inc;
    if (reset) begin
      bus.pc_next = '0;
    end else if (bus.flush) begin
      bus.pc_next = bus.target;
    end else if (bus.stall) begin
      bus.pc_next = bus.pc_in;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (reset) begin
      state_d = EMPTY;
      pc_d    = '0;
      instr_d = '0;
    end else if (bus.flush) begin
      // Flush wins over stall; instr_in is never sampled here so X cannot leak.
      state_d = BUBBLE;
      pc_d    = bus.pc_in;
      instr_d = '0;
    end else if (!bus.stall) begin
      state_d = FULL;
      pc_d    = bus.pc_in;
      instr_d = bus.instr_in;
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign bus.pc_out    = pc_q;
  assign bus.instr_out = instr_q;
  assign bus.valid_out = (state_q == FULL);

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (bus.stall && !bus.flush && (state_q == FULL) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`endif

endmodule
